ptp_fe_bridge: RTL and testbench

Front-end bridge downstream of the KA10 paper tape punch.
- Services the punch's front-end request line by issuing a single-cycle read of the punched frame, and pushes the 8-bit frame into a FIFO.
- Exposes the FIFO, tape-loaded control and a frame counter to the host through an Avalon-MM slave.
- Withholding reads when the FIFO is full stalls the punch: its done pulse needs the read. This gives lossless flow control.

---
 rtl/ptp_fe_pkg.sv | 31 +++
 rtl/ptp_fe_fifo.sv | 56 +++++
 rtl/ptp_fe_bridge.sv | 155 +++++++++++++++
 tb/tb_ptp_fe_bridge.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_fe_pkg.sv
// Shared constants and types for the paper tape punch front-end bridge.
// Register map, STATUS/CTRL bit positions and the request FSM states.
package ptp_fe_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_FRAMES = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int STAT_NO_TAPE = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_BUSY    = 3;
    localparam int STAT_IRQ_EN  = 4;
    localparam int STAT_CNT_LSB = 8;

    localparam int CTRL_NO_TAPE = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int DATA_VALID   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_READ,
        ST_DROP
    } ptp_state_t;

endpackage

// File: rtl/ptp_fe_fifo.sv
// Synchronous 8-bit first-word-fall-through FIFO with flush.
// Simultaneous push and pop is accepted even when full; flush overrides both.
module ptp_fe_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)
                count_reg <= count_reg + (AW+1)'(1);
            else if (do_pop && !do_push)
                count_reg <= count_reg - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ptp_fe_bridge.sv
// Bridges the KA10 paper tape punch front end to an Avalon-MM host slave.
// Frames are read only when the FIFO has room, which back-pressures the punch.
module ptp_fe_bridge
    import ptp_fe_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int RQ_SETTLE = 4,
    parameter int IRQ_LEVEL = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ptp_data_rq,
    output logic        ptp_read,
    input  logic [31:0] ptp_readdata,
    output logic        ptp_write,
    output logic [31:0] ptp_writedata,
    input  logic [1:0]  h_address,
    input  logic        h_read,
    output logic [31:0] h_readdata,
    input  logic        h_write,
    input  logic [31:0] h_writedata,
    output logic        host_irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (RQ_SETTLE > 1) ? $clog2(RQ_SETTLE) : 1;

    ptp_state_t    state_reg, state_next;
    logic [SW-1:0] settle_reg, settle_next;

    logic          no_tape_reg;
    logic          irq_en_reg;
    logic          ptp_write_reg;
    logic          host_irq_reg;
    logic [15:0]   frame_cnt_reg;

    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count_ext;

    logic          host_pop;
    logic          ctrl_wr;
    logic          flush;
    logic          frames_clr;
    logic          unused_bits;

    assign host_pop   = h_read && (h_address == ADDR_DATA);
    assign ctrl_wr    = h_write && (h_address == ADDR_CTRL);
    assign flush      = ctrl_wr && h_writedata[CTRL_FLUSH];
    assign frames_clr = h_write && (h_address == ADDR_FRAMES);
    assign count_ext  = 8'(fifo_count);
    assign unused_bits = ^{ptp_readdata[31:8], h_writedata[31:3]};

    ptp_fe_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (state_reg == ST_READ),
        .push_data (ptp_readdata[7:0]),
        .pop       (host_pop),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ptp_data_rq && !fifo_full) begin
                    state_next  = ST_SETTLE;
                    settle_next = SW'(RQ_SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (!ptp_data_rq)
                    state_next = ST_IDLE;
                else if (settle_reg == '0)
                    state_next = ST_READ;
                else
                    settle_next = settle_reg - SW'(1);
            end
            ST_READ:  state_next = ST_DROP;
            // Hold off until the punch has cleared its request register.
            ST_DROP: begin
                if (!ptp_data_rq)
                    state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            no_tape_reg   <= 1'b1;
            irq_en_reg    <= 1'b0;
            ptp_write_reg <= 1'b0;
            host_irq_reg  <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            ptp_write_reg <= ctrl_wr;
            if (ctrl_wr) begin
                no_tape_reg <= h_writedata[CTRL_NO_TAPE];
                irq_en_reg  <= h_writedata[CTRL_IRQ_EN];
            end
            // A host clear wins over a coincident frame increment.
            if (frames_clr)
                frame_cnt_reg <= '0;
            else if (state_reg == ST_READ)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            host_irq_reg <= irq_en_reg && (count_ext >= 8'(IRQ_LEVEL));
        end
    end

    assign ptp_read      = (state_reg == ST_READ);
    assign ptp_write     = ptp_write_reg;
    assign ptp_writedata = {31'b0, no_tape_reg};
    assign host_irq      = host_irq_reg;

    always_comb begin
        h_readdata = '0;
        case (h_address)
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    h_readdata[7:0]        = fifo_head;
                    h_readdata[DATA_VALID] = 1'b1;
                end
            end
            ADDR_STATUS: begin
                h_readdata[STAT_NO_TAPE]                 = no_tape_reg;
                h_readdata[STAT_EMPTY]                   = fifo_empty;
                h_readdata[STAT_FULL]                    = fifo_full;
                h_readdata[STAT_BUSY]                    = (state_reg != ST_IDLE);
                h_readdata[STAT_IRQ_EN]                  = irq_en_reg;
                h_readdata[STAT_CNT_LSB+7:STAT_CNT_LSB]  = count_ext;
            end
            ADDR_FRAMES: h_readdata = {16'b0, frame_cnt_reg};
            default:     h_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ptp_fe_bridge.sv
// Directed plus randomized bench for ptp_fe_bridge against a queue-based model.
module tb_ptp_fe_bridge;
    localparam int DEPTH     = 16;
    localparam int RQ_SETTLE = 4;
    localparam int IRQ_LEVEL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ptp_data_rq = 1'b0;
    logic        ptp_read;
    logic [31:0] ptp_readdata = '0;
    logic        ptp_write;
    logic [31:0] ptp_writedata;
    logic [1:0]  h_address = '0;
    logic        h_read = 1'b0;
    logic [31:0] h_readdata;
    logic        h_write = 1'b0;
    logic [31:0] h_writedata = '0;
    logic        host_irq;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0] model_q[$];
    int         model_frames = 0;
    bit         model_no_tape = 1'b1;
    bit         model_irq_en = 1'b0;

    ptp_fe_bridge #(.DEPTH(DEPTH), .RQ_SETTLE(RQ_SETTLE), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .clk           (clk),
        .reset         (reset),
        .ptp_data_rq   (ptp_data_rq),
        .ptp_read      (ptp_read),
        .ptp_readdata  (ptp_readdata),
        .ptp_write     (ptp_write),
        .ptp_writedata (ptp_writedata),
        .h_address     (h_address),
        .h_read        (h_read),
        .h_readdata    (h_readdata),
        .h_write       (h_write),
        .h_writedata   (h_writedata),
        .host_irq      (host_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-18s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] status_exp(input bit busy);
        logic [31:0] s;
        int n;
        n = model_q.size();
        s = '0;
        s[0] = model_no_tape;
        s[1] = (n == 0);
        s[2] = (n == DEPTH);
        s[3] = busy;
        s[4] = model_irq_en;
        s[15:8] = 8'(n);
        return s;
    endfunction

    task automatic host_write(input logic [1:0] a, input logic [31:0] d);
        h_address = a;
        h_writedata = d;
        h_write = 1'b1;
        tick();
        h_write = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] a, output logic [31:0] d);
        h_address = a;
        h_read = 1'b1;
        #1;
        d = h_readdata;
        @(posedge clk);
        #1;
        h_read = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = '0;
        if (model_q.size() > 0) begin
            e = {23'b0, 1'b1, model_q[0]};
            void'(model_q.pop_front());
        end
        host_read(2'd0, d);
        check(tag, d, e);
    endtask

    task automatic wait_read(input int bound, output int cycles, output bit seen);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < bound) begin
            tick();
            cycles++;
            if (ptp_read) seen = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [7:0] d, input bit check_lat);
        logic [31:0] r;
        int c;
        bit s;
        r = $urandom();
        r[7:0] = d;
        ptp_readdata = r;
        ptp_data_rq = 1'b1;
        wait_read(50, c, s);
        check("read_seen", 32'(s), 32'd1);
        if (check_lat) check("read_latency", 32'(c), 32'(RQ_SETTLE + 1));
        ptp_data_rq = 1'b0;
        tick();
        check("read_one_cycle", 32'(ptp_read), 32'd0);
        tick();
        model_q.push_back(d);
        model_frames = (model_frames + 1) & 32'hFFFF;
    endtask

    initial begin
        logic [31:0] d;
        int c;
        bit s;
        bit any_read;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        host_read(2'd1, d);
        check("reset_status", d, 32'h3);
        check("reset_irq", 32'(host_irq), 32'd0);
        check("reset_ptp_read", 32'(ptp_read), 32'd0);
        check("reset_ptp_write", 32'(ptp_write), 32'd0);

        // CTRL write: load the tape
        host_write(2'd1, 32'h0);
        model_no_tape = 1'b0;
        check("ctrl_ptp_write", 32'(ptp_write), 32'd1);
        check("ctrl_writedata", ptp_writedata, 32'h0);
        tick();
        check("ctrl_write_once", 32'(ptp_write), 32'd0);
        host_read(2'd1, d);
        check("status_tape", d, status_exp(1'b0));

        // Single frame
        do_frame(8'hA5, 1'b1);
        pop_check("data_a5");
        pop_check("data_empty");
        host_read(2'd2, d);
        check("frames_one", d, 32'(model_frames));

        // Short request pulse
        any_read = 1'b0;
        ptp_data_rq = 1'b1;
        repeat (3) begin tick(); if (ptp_read) any_read = 1'b1; end
        ptp_data_rq = 1'b0;
        repeat (8) begin tick(); if (ptp_read) any_read = 1'b1; end
        check("short_rq_noread", 32'(any_read), 32'd0);
        host_read(2'd1, d);
        check("short_rq_status", d, status_exp(1'b0));

        // Fill the FIFO, then a 17th request must stall
        for (int i = 0; i < DEPTH; i++) do_frame(8'($urandom()), 1'b0);
        host_read(2'd1, d);
        check("full_status", d, status_exp(1'b0));
        ptp_readdata = 32'h0000_003C;
        ptp_data_rq = 1'b1;
        wait_read(20, c, s);
        check("full_no_read", 32'(s), 32'd0);
        host_read(2'd1, d);
        check("full_pending", d, status_exp(1'b0));
        pop_check("full_pop");
        wait_read(30, c, s);
        check("after_pop_read", 32'(s), 32'd1);
        ptp_data_rq = 1'b0;
        repeat (2) tick();
        model_q.push_back(8'h3C);
        model_frames++;
        host_read(2'd1, d);
        check("refull_status", d, status_exp(1'b0));
        for (int i = 0; i < DEPTH; i++) pop_check("drain_order");
        pop_check("drain_empty");

        // Interrupt threshold and lag
        host_write(2'd1, 32'h4);
        model_irq_en = 1'b1;
        for (int i = 0; i < IRQ_LEVEL - 1; i++) do_frame(8'($urandom()), 1'b0);
        tick();
        check("irq_below", 32'(host_irq), 32'd0);
        do_frame(8'($urandom()), 1'b0);
        check("irq_at_level", 32'(host_irq), 32'd1);
        pop_check("irq_pop");
        check("irq_lag", 32'(host_irq), 32'd1);
        tick();
        check("irq_cleared", 32'(host_irq), 32'd0);
        host_write(2'd1, 32'h2);
        model_irq_en = 1'b0;
        model_q.delete();
        host_read(2'd1, d);
        check("flush_status", d, status_exp(1'b0));

        // Flush coincident with the READ-cycle push
        ptp_readdata = 32'h0000_0077;
        ptp_data_rq = 1'b1;
        wait_read(50, c, s);
        check("flush_read_seen", 32'(s), 32'd1);
        host_write(2'd1, 32'h2);
        ptp_data_rq = 1'b0;
        tick();
        model_frames++;
        host_read(2'd1, d);
        check("flush_push_empty", d, status_exp(1'b0));
        host_read(2'd2, d);
        check("flush_frames", d, 32'(model_frames));

        // FRAMES clear coincident with an increment
        ptp_readdata = 32'h0000_0011;
        ptp_data_rq = 1'b1;
        wait_read(50, c, s);
        check("clr_read_seen", 32'(s), 32'd1);
        host_write(2'd2, $urandom());
        ptp_data_rq = 1'b0;
        tick();
        model_frames = 0;
        model_q.push_back(8'h11);
        host_read(2'd2, d);
        check("frames_clr_wins", d, 32'(model_frames));
        host_read(2'd3, d);
        check("reserved_zero", d, 32'h0);

        // Randomized push/pop/status traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: if (model_q.size() < DEPTH) do_frame(8'($urandom()), 1'b0);
                1: pop_check("rand_pop");
                default: begin
                    host_read(2'd1, d);
                    check("rand_status", d, status_exp(1'b0));
                end
            endcase
        end
        host_read(2'd2, d);
        check("rand_frames", d, 32'(model_frames));

        // Reset during SETTLE abandons the read
        ptp_readdata = 32'h0000_00EE;
        ptp_data_rq = 1'b1;
        tick();
        host_read(2'd1, d);
        check("settle_busy", d, status_exp(1'b1));
        any_read = 1'b0;
        if (ptp_read) any_read = 1'b1;
        reset = 1'b1;
        ptp_data_rq = 1'b0;
        tick();
        if (ptp_read) any_read = 1'b1;
        reset = 1'b0;
        model_q.delete();
        model_frames = 0;
        model_no_tape = 1'b1;
        model_irq_en = 1'b0;
        repeat (10) begin tick(); if (ptp_read) any_read = 1'b1; end
        check("rst_no_read", 32'(any_read), 32'd0);
        host_read(2'd1, d);
        check("rst_status", d, status_exp(1'b0));
        host_read(2'd2, d);
        check("rst_frames", d, 32'(model_frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
